// File: rtl/rv32i_types.sv
// Shared RV32I encodings for the memory stage: load/store width codes and the
// data-memory handshake FSM state type.
package rv32i_types;

   typedef enum logic [2:0] {
      lb  = 3'b000,
      lh  = 3'b001,
      lw  = 3'b010,
      lbu = 3'b100,
      lhu = 3'b101
   } load_funct3_t;

   typedef enum logic [2:0] {
      sb = 3'b000,
      sh = 3'b001,
      sw = 3'b010
   } store_funct3_t;

   // Plain vector constants keep the state encoding visible to legacy tools.
   typedef logic [1:0] dmem_state_t;
   localparam dmem_state_t DMEM_IDLE = 2'd0;
   localparam dmem_state_t DMEM_BUSY = 2'd1;
   localparam dmem_state_t DMEM_DONE = 2'd2;

endpackage

// File: rtl/dmem_align.sv
// Combinational lane logic for the memory stage: store mask/shift, load shift/extend
// and, when DMEM_MISALIGN_TRAP_EN is defined, misaligned-access detection.
module dmem_align
   import rv32i_types::*;
(
   input  logic        is_store_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [1:0]  req_off_i,
   input  logic [31:0] req_wdata_i,
   output logic [3:0]  wmask_o,
   output logic [31:0] wdata_o,
   output logic        misalign_o,
   input  logic [2:0]  ld_funct3_i,
   input  logic [1:0]  ld_off_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] load_data_o
);

   logic [31:0] raw;

   // Lanes shifted past byte 3 are simply dropped, giving truncated partial writes.
   always_comb begin
      wmask_o = 4'b0000;
      if (is_store_i) begin
         case (store_funct3_t'(req_funct3_i))
            sb:      wmask_o = 4'b0001 << req_off_i;
            sh:      wmask_o = 4'b0011 << req_off_i;
            sw:      wmask_o = 4'b1111;
            default: wmask_o = 4'b0000;
         endcase
      end
   end

   assign wdata_o = is_store_i ? (req_wdata_i << {req_off_i, 3'b000}) : 32'd0;

   assign raw = rdata_i >> {ld_off_i, 3'b000};

   always_comb begin
      load_data_o = raw;
      case (load_funct3_t'(ld_funct3_i))
         lb:      load_data_o = {{24{raw[7]}}, raw[7:0]};
         lh:      load_data_o = {{16{raw[15]}}, raw[15:0]};
         lw:      load_data_o = raw;
         lbu:     load_data_o = {24'd0, raw[7:0]};
         lhu:     load_data_o = {16'd0, raw[15:0]};
         default: load_data_o = raw;
      endcase
   end

`ifdef DMEM_MISALIGN_TRAP_EN
   always_comb begin
      misalign_o = 1'b0;
      if (is_store_i) begin
         case (store_funct3_t'(req_funct3_i))
            sh:      misalign_o = req_off_i[0];
            sw:      misalign_o = |req_off_i;
            default: misalign_o = 1'b0;
         endcase
      end else begin
         case (load_funct3_t'(req_funct3_i))
            lh, lhu: misalign_o = req_off_i[0];
            lw:      misalign_o = |req_off_i;
            default: misalign_o = 1'b0;
         endcase
      end
   end
`else
   assign misalign_o = 1'b0;
`endif

endmodule

// File: rtl/dmem_interface.sv
// Memory-stage data-memory handshake: IDLE/BUSY/DONE FSM, request latching and
// load result register. Misalign trapping is enabled by DMEM_MISALIGN_TRAP_EN.
module dmem_interface
   import rv32i_types::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        dmem_read,
   input  logic        dmem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] mem_address,
   output logic        mem_read,
   output logic        mem_write,
   output logic [3:0]  mem_wmask,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_resp,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        misaligned
);

   dmem_state_t state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic [3:0]  wmask_q, wmask_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] load_data_q, load_data_d;
   logic        misaligned_q, misaligned_d;

   logic        req;
   logic        busy;
   logic [3:0]  st_mask;
   logic [31:0] st_wdata;
   logic        mis_det;
   logic [31:0] ld_ext;

   assign req  = dmem_read | dmem_write;
   assign busy = (state_q == DMEM_BUSY);

   // Store lanes come from the live request; load extension uses the latched width/offset.
   dmem_align u_align (
      .is_store_i   (dmem_write),
      .req_funct3_i (funct3),
      .req_off_i    (addr[1:0]),
      .req_wdata_i  (wdata),
      .wmask_o      (st_mask),
      .wdata_o      (st_wdata),
      .misalign_o   (mis_det),
      .ld_funct3_i  (funct3_q),
      .ld_off_i     (off_q),
      .rdata_i      (mem_rdata),
      .load_data_o  (ld_ext)
   );

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      rd_d         = rd_q;
      wr_d         = wr_q;
      wmask_d      = wmask_q;
      wdata_d      = wdata_q;
      funct3_d     = funct3_q;
      off_d        = off_q;
      load_data_d  = load_data_q;
      misaligned_d = misaligned_q;
      case (state_q)
         DMEM_IDLE: begin
            if (req) begin
               if (mis_det) begin
                  state_d      = DMEM_DONE;
                  misaligned_d = 1'b1;
               end else begin
                  state_d  = DMEM_BUSY;
                  addr_d   = {addr[31:2], 2'b00};
                  rd_d     = dmem_read & ~dmem_write;
                  wr_d     = dmem_write;
                  wmask_d  = st_mask;
                  wdata_d  = st_wdata;
                  funct3_d = funct3;
                  off_d    = addr[1:0];
               end
            end
         end
         DMEM_BUSY: begin
            if (mem_resp) begin
               state_d = DMEM_DONE;
               if (rd_q) begin
                  load_data_d = ld_ext;
               end
            end
         end
         DMEM_DONE: begin
            // The stage's inputs still show the finished instruction here; never re-accept.
            state_d      = DMEM_IDLE;
            misaligned_d = 1'b0;
            rd_d         = 1'b0;
            wr_d         = 1'b0;
         end
         default: begin
            state_d = DMEM_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= DMEM_IDLE;
         addr_q       <= 32'd0;
         rd_q         <= 1'b0;
         wr_q         <= 1'b0;
         wmask_q      <= 4'd0;
         wdata_q      <= 32'd0;
         funct3_q     <= 3'd0;
         off_q        <= 2'd0;
         load_data_q  <= 32'd0;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         rd_q         <= rd_d;
         wr_q         <= wr_d;
         wmask_q      <= wmask_d;
         wdata_q      <= wdata_d;
         funct3_q     <= funct3_d;
         off_q        <= off_d;
         load_data_q  <= load_data_d;
         misaligned_q <= misaligned_d;
      end
   end

   assign mem_read    = busy & rd_q;
   assign mem_write   = busy & wr_q;
   assign mem_address = busy ? addr_q  : 32'd0;
   assign mem_wmask   = busy ? wmask_q : 4'd0;
   assign mem_wdata   = busy ? wdata_q : 32'd0;
   assign stall       = ((state_q == DMEM_IDLE) & req) | busy;
   assign load_data   = load_data_q;
   assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_dmem_interface.sv
// Directed scoreboard bench for dmem_interface; expectations are queued when a
// request is driven and popped when the DUT reaches BUSY/DONE.
module tb_dmem_interface;

   logic        clk = 1'b0;
   logic        rst;
   logic        dmem_read, dmem_write;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic [31:0] mem_address;
   logic        mem_read, mem_write;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_wdata, mem_rdata;
   logic        mem_resp;
   logic        stall;
   logic [31:0] load_data;
   logic        misaligned;

   int n_vec  = 0;
   int n_miss = 0;

   typedef struct {
      logic        trap;
      logic        rd;
      logic        wr;
      logic [31:0] maddr;
      logic [3:0]  mask;
      logic [31:0] mwdata;
      logic [31:0] ld;
      logic        mis;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   dmem_interface dut (
      .clk         (clk),
      .rst         (rst),
      .dmem_read   (dmem_read),
      .dmem_write  (dmem_write),
      .funct3      (funct3),
      .addr        (addr),
      .wdata       (wdata),
      .mem_address (mem_address),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_wmask   (mem_wmask),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_resp    (mem_resp),
      .stall       (stall),
      .load_data   (load_data),
      .misaligned  (misaligned)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic trap, input logic rd, input logic wr,
                               input logic [31:0] maddr, input logic [3:0] mask,
                               input logic [31:0] mwdata, input logic [31:0] ld,
                               input logic mis);
      exp_t e;
      e.trap = trap; e.rd = rd; e.wr = wr; e.maddr = maddr; e.mask = mask;
      e.mwdata = mwdata; e.ld = ld; e.mis = mis;
      return e;
   endfunction

   // One full transaction: IDLE request, waits+1 BUSY cycles (or a trap), DONE, then IDLE.
   task automatic run_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                         input int waits, input exp_t e);
      exp_t got;
      int   stalls;
      int   exp_stalls;
      @(negedge clk);
      dmem_read = rd; dmem_write = wr; funct3 = f3; addr = a; wdata = wd;
      sb_q.push_back(e);
      #1 chk({tag, ".idle_stall"}, {31'd0, stall}, 32'd1);
      stalls = 1;
      got = sb_q.pop_front();
      if (!got.trap) begin
         for (int k = 0; k <= waits; k++) begin
            @(negedge clk);
            mem_resp  = (k == waits);
            mem_rdata = rdat;
            #1;
            if (stall) stalls++;
            chk({tag, ".rd"},    {31'd0, mem_read},  {31'd0, got.rd});
            chk({tag, ".wr"},    {31'd0, mem_write}, {31'd0, got.wr});
            chk({tag, ".maddr"}, mem_address, got.maddr);
            chk({tag, ".mask"},  {28'd0, mem_wmask}, {28'd0, got.mask});
            if (got.wr) chk({tag, ".wdata"}, mem_wdata, got.mwdata);
         end
      end
      @(negedge clk);
      mem_resp = 1'b0; mem_rdata = 32'd0;
      #1;
      exp_stalls = got.trap ? 1 : 2 + waits;
      chk({tag, ".stall_cycles"}, stalls, exp_stalls);
      chk({tag, ".done_stall"}, {31'd0, stall}, 32'd0);
      chk({tag, ".done_strobes"}, {30'd0, mem_read, mem_write}, 32'd0);
      chk({tag, ".load_data"}, load_data, got.ld);
      chk({tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, got.mis});
      @(negedge clk);
      dmem_read = 1'b0; dmem_write = 1'b0;
      #1;
      chk({tag, ".idle_after"}, {30'd0, mem_read, mem_write, stall} , 32'd0);
   endtask

   initial begin
      rst = 1'b1; dmem_read = 1'b0; dmem_write = 1'b0; funct3 = 3'd0;
      addr = 32'd0; wdata = 32'd0; mem_rdata = 32'd0; mem_resp = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset.outputs", {mem_read, mem_write, stall, misaligned, mem_wmask}, 32'd0);
      chk("reset.maddr", mem_address, 32'd0);
      chk("reset.load_data", load_data, 32'd0);

      // Reset while BUSY: strobes drop at once and a late response is ignored.
      @(negedge clk);
      dmem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_0200;
      @(negedge clk);
      #1 chk("rstbusy.rd_before", {31'd0, mem_read}, 32'd1);
      rst = 1'b1; dmem_read = 1'b0;
      #1;
      chk("rstbusy.strobes", {30'd0, mem_read, mem_write}, 32'd0);
      chk("rstbusy.stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      rst = 1'b0; mem_resp = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      mem_resp = 1'b0;
      #1;
      chk("rstbusy.after_resp", {30'd0, mem_read, stall}, 32'd0);
      chk("rstbusy.load_data", load_data, 32'd0);

      run_op("sw100", 1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'd0, 0,
             mk(0, 0, 1, 32'h100, 4'b1111, 32'hDEAD_BEEF, 32'd0, 0));
      run_op("lb103", 1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 32'h8000_0000, 0,
             mk(0, 1, 0, 32'h100, 4'b0000, 32'd0, 32'hFFFF_FF80, 0));
      run_op("lbu103", 1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 32'h8000_0000, 0,
             mk(0, 1, 0, 32'h100, 4'b0000, 32'd0, 32'h0000_0080, 0));
      run_op("sh102", 1'b0, 1'b1, 3'b001, 32'h102, 32'h0000_ABCD, 32'd0, 3,
             mk(0, 0, 1, 32'h100, 4'b1100, 32'hABCD_0000, 32'h0000_0080, 0));
      run_op("lh102", 1'b1, 1'b0, 3'b001, 32'h102, 32'd0, 32'h8001_0000, 1,
             mk(0, 1, 0, 32'h100, 4'b0000, 32'd0, 32'hFFFF_8001, 0));
      run_op("lhu102", 1'b1, 1'b0, 3'b101, 32'h102, 32'd0, 32'h8001_0000, 0,
             mk(0, 1, 0, 32'h100, 4'b0000, 32'd0, 32'h0000_8001, 0));
      run_op("lw104", 1'b1, 1'b0, 3'b010, 32'h104, 32'd0, 32'h1234_5678, 2,
             mk(0, 1, 0, 32'h104, 4'b0000, 32'd0, 32'h1234_5678, 0));
      run_op("sb101", 1'b0, 1'b1, 3'b000, 32'h101, 32'h0000_00A5, 32'd0, 0,
             mk(0, 0, 1, 32'h100, 4'b0010, 32'h0000_A500, 32'h1234_5678, 0));
      run_op("rdwr108", 1'b1, 1'b1, 3'b010, 32'h108, 32'h1122_3344, 32'hFFFF_FFFF, 0,
             mk(0, 0, 1, 32'h108, 4'b1111, 32'h1122_3344, 32'h1234_5678, 0));
      run_op("sundef", 1'b0, 1'b1, 3'b011, 32'h10C, 32'h0000_0055, 32'd0, 0,
             mk(0, 0, 1, 32'h10C, 4'b0000, 32'h0000_0055, 32'h1234_5678, 0));
      run_op("lundef", 1'b1, 1'b0, 3'b011, 32'h10E, 32'd0, 32'hAABB_CCDD, 0,
             mk(0, 1, 0, 32'h10C, 4'b0000, 32'd0, 32'h0000_AABB, 0));
`ifdef DMEM_MISALIGN_TRAP_EN
      run_op("lw101", 1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 32'hCAFE_F00D, 0,
             mk(1, 0, 0, 32'd0, 4'b0000, 32'd0, 32'h0000_AABB, 1));
      run_op("sh103", 1'b0, 1'b1, 3'b001, 32'h103, 32'h0000_ABCD, 32'd0, 0,
             mk(1, 0, 0, 32'd0, 4'b0000, 32'd0, 32'h0000_AABB, 1));
      run_op("lb101", 1'b1, 1'b0, 3'b000, 32'h101, 32'd0, 32'h0000_7F00, 0,
             mk(0, 1, 0, 32'h100, 4'b0000, 32'd0, 32'h0000_007F, 0));
`else
      run_op("lw101", 1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 32'hCAFE_F00D, 0,
             mk(0, 1, 0, 32'h100, 4'b0000, 32'd0, 32'h00CA_FEF0, 0));
      run_op("sh103", 1'b0, 1'b1, 3'b001, 32'h103, 32'h0000_ABCD, 32'd0, 1,
             mk(0, 0, 1, 32'h100, 4'b1000, 32'hCD00_0000, 32'h00CA_FEF0, 0));
`endif

      // A response with no access outstanding must not disturb anything.
      @(negedge clk);
      mem_resp = 1'b1; mem_rdata = 32'h5555_5555;
      #1 chk("stray_resp.stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      mem_resp = 1'b0;
      #1;
      chk("stray_resp.strobes", {30'd0, mem_read, mem_write}, 32'd0);
`ifdef DMEM_MISALIGN_TRAP_EN
      chk("stray_resp.load_data", load_data, 32'h0000_007F);
`else
      chk("stray_resp.load_data", load_data, 32'h00CA_FEF0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
